led_matrix_scanner: RTL and testbench
=====================================

# led_matrix_scanner

Row-multiplexed driver for the 6x6 LED matrix that consumes the 36-bit `leds` frame produced by the game core and renders it onto the physical row/column pins. It is the reader end of the core's LED frame output. A pending buffer plus a display buffer keep frame updates from tearing mid-scan. Row scan and anti-ghosting blanking are timed by an internal prescaler.

## Interface

**Parameters**
- `ROWS`, default 6: matrix rows.
- `COLS`, default 6: matrix columns.
- `SCAN_DIV`, default 50000: clock cycles per row slot. Must satisfy `SCAN_DIV` ≥ 2.
- `BLANK_CYCLES`, default 500: cycles at the start of each row slot with all LEDs off. Must satisfy 1 ≤ `BLANK_CYCLES` < `SCAN_DIV`.

**Ports** (one clock; reset is asynchronous and active-high)
- `clock` in 1: system clock, 50 MHz.
- `restart` in 1: asynchronous active-high reset.
- `frame` in ROWS*COLS: LED frame. Bit `r*COLS+c` lights row r, column c.
- `frame_valid` in 1: single-cycle strobe that captures `frame` into the pending buffer.
- `enable` in 1: scan enable. Low forces the matrix dark.
- `row_sel` out ROWS: one-hot, active-high row drive.
- `col_n` out COLS: active-low column drive. Bit c lights column c.
- `frame_done` out 1: one-cycle pulse during the last cycle of a full frame scan.
- `db_row` out 3: current row index, for debug.

## Operation

- **States**
  - IDLE: outputs off.
  - BLANK: row slot cycles 0..BLANK_CYCLES-1, outputs off.
  - DRIVE: cycles BLANK_CYCLES..SCAN_DIV-1. `row_sel` = one-hot(row). `col_n[c]` = ~disp[row*COLS+c].
- **Transitions**
  - IDLE→BLANK when `enable`=1. Row=0, cnt=0.
  - BLANK→DRIVE when cnt=BLANK_CYCLES-1.
  - DRIVE→BLANK when cnt=SCAN_DIV-1. cnt resets to 0. Row increments and wraps ROWS-1→0.
  - Any state→IDLE when `enable`=0. Row and cnt return to 0.
- **Buffers**
  - `frame_valid`=1: pending←`frame`, pend_flag←1. The last strobe before a swap wins.
  - Swap occurs at the clock edge ending cnt=SCAN_DIV-1 of row ROWS-1 with `enable`=1. If pend_flag=1, then disp←pending and pend_flag←0. Otherwise disp is unchanged.
  - `frame_valid` coincident with the swap edge: the swap uses the pending value from before this edge. The new frame is written to pending and pend_flag stays 1, so it displays after the next swap.
- **Frame done:** `frame_done`=1 exactly while cnt=SCAN_DIV-1, row=ROWS-1 and the state is DRIVE.
- **Capture while disabled:** `frame_valid` is honored in every state, including IDLE. No swap happens while disabled.
- **Counter width:** cnt is clog2(SCAN_DIV) bits and never exceeds SCAN_DIV-1.
- **Decode:** all outputs are decoded from registered state only. There is no combinational input-to-output path.

## Timing

- **Reset values:** state=IDLE, row=0, cnt=0, `row_sel`=0, `col_n`=all ones, `frame_done`=0, `db_row`=0, disp=0, pending=0, pend_flag=0.
- **Reset mid-scan:** outputs go off immediately (asynchronous) and all buffers clear.
- **Enable latency:** if `enable` is sampled high at edge k, the first BLANK cycle follows edge k. The first DRIVE (row 0 lit) starts BLANK_CYCLES cycles later.
- **Disable latency:** if `enable` is sampled low at edge k, outputs are off from edge k.
- **Periods:** row period is SCAN_DIV cycles. Frame period is ROWS*SCAN_DIV cycles (300000 by default, about 6 ms, about 167 Hz).
- **Update latency:** a frame strobed at any time is displayed from row 0 of the scan that follows the next `frame_done` edge. Worst case is ROWS*SCAN_DIV cycles plus one.

## Test plan

All scenarios use ROWS=6, COLS=6, SCAN_DIV=4, BLANK_CYCLES=1, giving a 24-cycle frame.

1. **Reset:** pulse `restart` with `enable`=1 -> `row_sel`=000000, `col_n`=111111 and `frame_done`=0 during reset and for 1 cycle after. `db_row`=0.
2. **Row sequence:** `enable`=1 with no frame -> each slot shows 1 cycle of `row_sel`=0 then 3 cycles of one-hot 000001, 000010, … 100000, repeating. `col_n` stays 111111. `frame_done` pulses every 24 cycles on the last cycle of row 5.
3. **First frame:** strobe `frame`=36'h000000001, then enable -> first frame all dark. After the first `frame_done`, row 0 DRIVE shows `col_n`=111110 and rows 1..5 show 111111.
4. **Double buffer:** while 36'h000000001 is displayed, strobe 36'hFFFFFFFFF at row 2 -> rows 2..5 of the current frame are unchanged. From the next row 0, every DRIVE cycle shows `col_n`=000000.
5. **Simultaneous strobe at swap:** pending holds 36'h00000003F. Strobe 36'hFC0000000 on the `frame_done` cycle -> the next frame shows row 0 `col_n`=000000. The frame after that shows row 5 `col_n`=000000 and row 0 dark.
6. **Enable drop mid-row 3, reassert after 5 cycles:** outputs are off the cycle after the drop. Scan restarts at row 0 BLANK and disp is retained.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 6x6 LED matrix driver. A pending/display buffer pair prevents tearing.
// Each row slot begins with a blanking interval to suppress ghosting.
module led_matrix_scanner #(
    parameter int unsigned ROWS         = 6,
    parameter int unsigned COLS         = 6,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                 clock,
    input  logic                 restart,
    input  logic [ROWS*COLS-1:0] frame,
    input  logic                 frame_valid,
    input  logic                 enable,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_n,
    output logic                 frame_done,
    output logic [2:0]           db_row
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CntW-1:0] CntLast   = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [RowW-1:0] RowLast   = RowW'(ROWS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StDrive
    } state_e;

    state_e                state_q, state_d;
    logic [RowW-1:0]       row_q, row_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ROWS*COLS-1:0]  disp_q, disp_d;
    logic [ROWS*COLS-1:0]  pending_q, pending_d;
    logic                  pend_flag_q, pend_flag_d;

    logic last_cycle;
    logic swap;

    assign last_cycle = (state_q == StDrive) && (cnt_q == CntLast) && (row_q == RowLast);
    assign swap       = last_cycle && enable;

    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            state_q     <= StIdle;
            row_q       <= '0;
            cnt_q       <= '0;
            disp_q      <= '0;
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            disp_q      <= disp_d;
            pending_q   <= pending_d;
            pend_flag_q <= pend_flag_d;
        end
    end

    // Scan sequencing: the counter runs across BLANK and DRIVE within one row slot.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = StIdle;
            row_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StBlank;
                    row_d   = '0;
                    cnt_d   = '0;
                end
                StBlank: begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == BlankLast) begin
                        state_d = StDrive;
                    end
                end
                StDrive: begin
                    if (cnt_q == CntLast) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        row_d   = (row_q == RowLast) ? '0 : row_q + RowW'(1);
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A strobe on the swap edge lands in pending after the old pending moves to display.
    always_comb begin
        disp_d      = disp_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        if (swap && pend_flag_q) begin
            disp_d      = pending_q;
            pend_flag_d = 1'b0;
        end
        if (frame_valid) begin
            pending_d   = frame;
            pend_flag_d = 1'b1;
        end
    end

    always_comb begin
        row_sel = '0;
        col_n   = '1;
        if (state_q == StDrive) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                if (row_q == RowW'(r)) begin
                    row_sel[r] = 1'b1;
                    col_n      = ~disp_q[r*COLS +: COLS];
                end
            end
        end
    end

    assign frame_done = last_cycle;
    assign db_row     = 3'(row_q);

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with a 4-cycle row slot and 1-cycle blanking.
module tb_led_matrix_scanner;

    localparam int ROWS  = 6;
    localparam int COLS  = 6;
    localparam int SDIV  = 4;
    localparam int BLANK = 1;
    localparam int FRAME = ROWS * SDIV;

    logic                 clock = 1'b0;
    logic                 restart;
    logic [ROWS*COLS-1:0] frame;
    logic                 frame_valid;
    logic                 enable;
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      col_n;
    logic                 frame_done;
    logic [2:0]           db_row;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          t;
    logic [ROWS*COLS-1:0] exp_disp;

    typedef struct packed {
        logic [ROWS-1:0] row;
        logic [COLS-1:0] col;
        logic            fd;
        logic [2:0]      db;
    } exp_t;

    typedef struct packed {
        logic                 en;
        logic                 fv;
        logic [ROWS*COLS-1:0] fr;
        exp_t                 exp;
    } vec_t;

    localparam exp_t OFF = '{row: '0, col: '1, fd: 1'b0, db: 3'd0};

    vec_t vecs[2*FRAME];

    always #5 clock = ~clock;

    led_matrix_scanner #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .SCAN_DIV    (SDIV),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clock      (clock),
        .restart    (restart),
        .frame      (frame),
        .frame_valid(frame_valid),
        .enable     (enable),
        .row_sel    (row_sel),
        .col_n      (col_n),
        .frame_done (frame_done),
        .db_row     (db_row)
    );

    // Expected outputs at cycle t after the scan starts, given the displayed frame.
    function automatic exp_t model(int tc, logic [ROWS*COLS-1:0] disp);
        exp_t e;
        int   r;
        int   ph;
        r     = (tc / SDIV) % ROWS;
        ph    = tc % SDIV;
        e     = OFF;
        e.db  = 3'(r);
        if (ph >= BLANK) begin
            e.row = 6'(1 << r);
            e.col = ~disp[r*COLS +: COLS];
        end
        e.fd = ((tc % FRAME) == FRAME - 1);
        return e;
    endfunction

    task automatic check(string name, exp_t e);
        n_checks++;
        if (row_sel === e.row && col_n === e.col && frame_done === e.fd && db_row === e.db) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0d: got row_sel=%b col_n=%b frame_done=%b db_row=%0d, want row_sel=%b col_n=%b frame_done=%b db_row=%0d",
                     name, t, row_sel, col_n, frame_done, db_row, e.row, e.col, e.fd, e.db);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check the current cycle, then drive the inputs sampled at the edge ending it.
    task automatic step(string name, logic fv, logic [ROWS*COLS-1:0] fr, logic en);
        check(name, model(t, exp_disp));
        frame_valid = fv;
        frame       = fr;
        enable      = en;
        tick();
        frame_valid = 1'b0;
        t++;
    endtask

    task automatic run(string name, int n);
        for (int i = 0; i < n; i++) step(name, 1'b0, '0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 2 * FRAME; i++) begin
            vecs[i].en  = 1'b1;
            vecs[i].fv  = 1'b0;
            vecs[i].fr  = '0;
            vecs[i].exp = model(i, '0);
        end

        // Reset with enable high: dark during reset and one cycle after.
        restart     = 1'b1;
        enable      = 1'b1;
        frame_valid = 1'b0;
        frame       = '0;
        #1;
        check("reset_async", OFF);
        tick();
        tick();
        check("reset_held", OFF);
        restart = 1'b0;
        tick();
        t = 0;

        // Row sequence with an empty frame, two full frames from the table.
        for (int i = 0; i < 2 * FRAME; i++) begin
            check("row_seq", vecs[i].exp);
            enable      = vecs[i].en;
            frame_valid = vecs[i].fv;
            frame       = vecs[i].fr;
            tick();
            t++;
        end

        // First frame: strobed while idle, shown only after the first frame_done.
        restart = 1'b1;
        #1;
        restart     = 1'b0;
        enable      = 1'b0;
        frame_valid = 1'b1;
        frame       = 36'h000000001;
        tick();
        frame_valid = 1'b0;
        check("idle_dark", OFF);
        enable = 1'b1;
        tick();
        t        = 0;
        exp_disp = '0;
        run("first_frame_dark", FRAME);
        exp_disp = 36'h000000001;
        run("first_frame_shown", 8);

        // Double buffer: strobe at row 2 does not affect the frame in progress.
        step("dbuf_strobe", 1'b1, 36'hFFFFFFFFF, 1'b1);
        run("dbuf_old_frame", 15);
        exp_disp = 36'hFFFFFFFFF;
        run("dbuf_new_frame", 2);

        // Strobe on the swap edge: old pending swaps in, new one waits a frame.
        step("swap_pre_strobe", 1'b1, 36'h00000003F, 1'b1);
        run("swap_wait", 20);
        step("swap_edge_strobe", 1'b1, 36'hFC0000000, 1'b1);
        exp_disp = 36'h00000003F;
        run("swap_old_pending", FRAME);
        exp_disp = 36'hFC0000000;
        run("swap_new_pending", 14);

        // Enable drop mid-row 3, reassert after 5 dark cycles.
        step("en_drop", 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("en_off", OFF);
            enable = (i == 4);
            tick();
        end
        t = 0;
        run("en_restart_retained", FRAME + 10);

        // Asynchronous reset mid-drive blanks at once and clears the display buffer.
        restart = 1'b1;
        #2;
        check("reset_mid_scan", OFF);
        restart = 1'b0;
        tick();
        t        = 0;
        exp_disp = '0;
        run("post_reset_dark", 2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
